// File: rtl/ram_rd_pkg.sv
// Shared FSM encoding and output-buffer sizing for the RAM burst reader.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous first-word-fall-through FIFO buffering read data plus a last flag.
module ram_rd_fifo
  import ram_rd_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [W-1:0]          wr_data_i,
  input  logic                  rd_en_i,
  output logic [W-1:0]          rd_data_o,
  output logic                  valid_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_wr;
  logic                  do_rd;

  assign valid_o   = (count_q != '0);
  assign do_rd     = rd_en_i && valid_o;
  assign do_wr     = wr_en_i && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_rd);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

  // NOTE: storage is deliberately not reset; the output is masked while empty,
  // so stale entries can never be observed and the array maps onto plain RAM cells.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive words from a registered-address single-port RAM
// and streams them out with valid/ready, flagging the final beat.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int msb      = 8,
  parameter int addrsize = 8
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                start,
  input  logic [addrsize-1:0] base_addr,
  input  logic [addrsize:0]   len,
  output logic                busy,
  output logic                done,
  output logic [addrsize-1:0] ram_addr,
  input  logic [msb-1:0]      ram_rdata,
  output logic [msb-1:0]      m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int unsigned PEND_W = FIFO_CNT_W + 1;
  localparam int unsigned LEN_W  = addrsize + 1;

  state_e                state_q, state_d;
  logic [addrsize-1:0]   addr_q, addr_d;
  logic [addrsize:0]     rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [PEND_W-1:0]     pending;
  logic                  fifo_valid;
  logic [msb:0]          fifo_rdata;
  logic                  pop;
  logic                  issue;
  logic                  final_issue;

  // Buffered words plus the read still in the RAM pipeline must fit in the FIFO.
  assign pending     = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, inflight_q};
  assign issue       = (state_q == ST_READ) && (pending < PEND_W'(FIFO_DEPTH));
  assign final_issue = issue && (rem_q == LEN_W'(1));
  assign pop         = fifo_valid && m_ready;

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no branch leaves one unassigned and infers a latch.
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = issue;
    inflight_last_d = final_issue;
    done_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
            addr_d  = base_addr;
            rem_d   = len;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + addrsize'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (final_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_rdata[msb]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  ram_rd_fifo #(
    .W(msb + 1)
  ) u_fifo (
    .clk_i    (clka),
    .rst_i    (rsta),
    .wr_en_i  (inflight_q),
    .wr_data_i({inflight_last_q, ram_rdata}),
    .rd_en_i  (m_ready),
    .rd_data_o(fifo_rdata),
    .valid_o  (fifo_valid),
    .count_o  (fifo_count)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign ram_addr = addr_q;
  assign m_valid  = fifo_valid;
  assign m_data   = fifo_rdata[msb-1:0];
  assign m_last   = fifo_rdata[msb];

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameter msb, default 8: data width in bits.
REQ-002 Parameter addrsize, default 8: RAM address width; depth = 2^addrsize words.
REQ-003 clka  in  1  single clock; all logic on rising edge.
REQ-004 rsta  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request a burst; sampled only when busy=0.
REQ-006 base_addr  in  addrsize  first word address, sampled with start.
REQ-007 len  in  addrsize+1  word count, 0..depth, sampled with start.
REQ-008 busy  out  1  burst in progress, from accepted start until the done cycle.
REQ-009 done  out  1  one-cycle pulse at burst completion.
REQ-010 ram_addr  out  addrsize  registered address driven to the single-port RAM address input; RAM write enable is tied low externally.
REQ-011 ram_rdata  in  msb  RAM read data; valid in the cycle after the cycle its address is driven.
REQ-012 m_data  out  msb  output stream data.
REQ-013 m_valid  out  1  output stream valid.
REQ-014 m_ready  in  1  output stream ready; beat transfers when m_valid and m_ready are both 1 at an edge.
REQ-015 m_last  out  1  marks the final beat of a burst.

Function
REQ-016 FSM states IDLE, READ, DRAIN; IDLE->READ on start with len>0; READ->DRAIN when len addresses issued; DRAIN->IDLE on last beat handshake.
REQ-017 start with len=0: no RAM reads, no beats, done=1 the next cycle, busy stays 0.
REQ-018 start while busy=1 is ignored; no queuing.
REQ-019 An issue is a cycle in READ where ram_addr holds a burst address and the issue condition holds; the address counter advances by 1 at that edge.
REQ-020 Issue condition: FIFO occupancy + in-flight reads < 4; at most one read in flight.
REQ-021 ram_rdata is written into the FIFO at the edge ending the cycle after the issue; no word is dropped or duplicated.
REQ-022 Latency: start accepted at edge 0 -> ram_addr=base_addr in cycle 1 -> m_valid=1 with mem[base_addr] in cycle 3.
REQ-023 With m_ready held at 1, throughput is one beat per cycle after the first.
REQ-024 Address arithmetic is modulo depth; base_addr+i wraps from depth-1 to 0.
REQ-025 m_data, m_last held stable while m_valid=1 and m_ready=0.
REQ-026 m_last=1 only on beat number len; done pulses the cycle after that handshake; busy falls with done.
REQ-027 ram_addr holds its last value when not issuing.

Reset
REQ-028 rsta=1 at an edge: state=IDLE, busy=0, done=0, m_valid=0, m_last=0, ram_addr=0, m_data=0, FIFO emptied, counters and in-flight flag cleared.
REQ-029 Reset mid-burst aborts it; no done pulse, no further beats; next start after reset behaves as from power-up.

Structure
REQ-030 Shared package/include ram_rd_pkg holds FSM state encodings and the FIFO depth constant (4).
REQ-031 Output buffering is one sub-module ram_rd_fifo: synchronous 4-entry FIFO, msb+1 bits wide (data plus last flag), first-word-fall-through output.
REQ-032 RTL integrates with the team's single-port RAM (registered-address read) without glue logic.

Verification
REQ-033 RAM preloaded mem[i]=i; start base=0x10, len=4, m_ready=1 -> beats 0x10,0x11,0x12,0x13, first m_valid cycle 3, m_last on 0x13, done one cycle later.
REQ-034 base=0xFE, len=4 -> beats 0xFE,0xFF,0x00,0x01; ram_addr wraps to 0.
REQ-035 len=8, m_ready toggled 1,0,0,1 repeating -> all 8 words in order, m_data stable during stalls, in-flight+occupancy never exceeds 4.
REQ-036 len=0 -> no m_valid, done=1 exactly one cycle after start, busy never 1.
REQ-037 start pulsed during an active len=6 burst -> ignored, exactly 6 beats emitted.
REQ-038 rsta asserted after third beat of len=10 burst -> m_valid=0, busy=0 next cycle, no done; subsequent base=0x20, len=2 returns 0x20,0x21.
